// File: rtl/aes_sub_bytes_engine.sv
// aes_sub_bytes_engine: iterative AES SubBytes / InvSubBytes over a 128-bit state
// Parameters:
//   LANES  bytes substituted per cycle (1, 2, 4, 8 or 16)
//   PIPE   0: lookup written back in the same cycle; 1: one register stage after lookup
// Ports:
//   clk, rst_n           clock (rising edge), synchronous active-low reset
//   in_valid/in_ready    input handshake; in_ready is high only in IDLE
//   in_mode              0 = SubBytes, 1 = InvSubBytes (sampled at accept)
//   in_data              input state, byte 0 at the MSB
//   out_valid/out_ready  output handshake
//   out_data             substituted state, same byte ordering, held while out_valid
//   busy                 high while running or holding a result
module aes_sub_bytes_engine #(
    parameter int LANES = 4,
    parameter int PIPE  = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_mode,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam int NG = 16 / LANES;
    localparam int CW = NG > 1 ? $clog2(NG) : 1;
    localparam int LB = $clog2(LANES);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) || (PIPE != 0 && PIPE != 1)) begin : g_bad
        $error("aes_sub_bytes_engine: LANES must be 1,2,4,8,16 and PIPE 0 or 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // multiplicative inverse as a^254 (a^2 * a^4 * ... * a^128); maps 0 to 0
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r, s;
        r = 8'h01;
        s = a;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    function automatic logic [7:0] rl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // forward: inverse then affine; inverse: inverse affine then inverse
    function automatic logic [7:0] sub(input logic [7:0] x, input logic m);
        logic [7:0] y;
        y = ginv(m ? rl(x, 1) ^ rl(x, 3) ^ rl(x, 6) ^ 8'h05 : x);
        return m ? y : y ^ rl(y, 1) ^ rl(y, 2) ^ rl(y, 3) ^ rl(y, 4) ^ 8'h63;
    endfunction

    state_t        s, s_n;
    logic [7:0]    dat [16];
    logic [7:0]    dat_n [16];
    logic [CW-1:0] c;
    logic          md, pv, dr, acc, last, wv;
    logic [7:0]    pr [LANES];
    logic [7:0]    lk [LANES];
    logic [7:0]    wd [LANES];
    logic [3:0]    base, pb, wb;
    logic [127:0]  od, pk;

    assign in_ready  = s == IDLE;
    assign out_valid = s == DONE;
    assign busy      = s != IDLE;
    assign out_data  = od;
    assign acc       = s == IDLE && in_valid;

    always_comb begin
        base = 4'(c) << LB;
        dat_n = dat;
        pk = '0;
        wb = PIPE != 0 ? pb : base;
        wv = PIPE != 0 ? pv : s == RUN;
        // with PIPE the drain flag marks the cycle that writes the final group
        last = PIPE != 0 ? dr : c == CW'(NG - 1);
        for (int j = 0; j < LANES; j++) begin
            lk[j] = sub(dat[base | 4'(j)], md);
            wd[j] = PIPE != 0 ? pr[j] : lk[j];
            if (wv) dat_n[wb | 4'(j)] = wd[j];
        end
        for (int i = 0; i < 16; i++) pk[127 - 8*i -: 8] = dat_n[i];
        s_n = acc ? RUN : (s == RUN && last) ? DONE : (s == DONE && out_ready) ? IDLE : s;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s  <= IDLE;
            c  <= '0;
            md <= 1'b0;
            pv <= 1'b0;
            dr <= 1'b0;
            pb <= '0;
            od <= '0;
            for (int j = 0; j < LANES; j++) pr[j] <= '0;
            for (int i = 0; i < 16; i++) dat[i] <= '0;
        end else begin
            s <= s_n;
            for (int i = 0; i < 16; i++) dat[i] <= acc ? in_data[127 - 8*i -: 8] : dat_n[i];
            if (acc) begin
                md <= in_mode;
                c  <= '0;
                pv <= 1'b0;
                dr <= 1'b0;
            end
            if (s == RUN && !dr) begin
                c  <= c == CW'(NG - 1) ? '0 : c + 1'b1;
                pr <= lk;
                pb <= base;
                pv <= 1'b1;
                dr <= PIPE != 0 && c == CW'(NG - 1);
            end
            if (s == RUN && dr) begin
                pv <= 1'b0;
                dr <= 1'b0;
            end
            // result register is loaded only with the completed state
            if (s == RUN && s_n == DONE) od <= pk;
        end
    end
endmodule
